// File: rtl/salidas_pkg.sv
// salidas_pkg: shared constants for the output-bus controller.
//   - outbus command mode encodings
//   - FSM state encodings
//   - layout helpers for a queued command entry, packed as {mode, addr, data}
//     with data in the least-significant bits.
package salidas_pkg;

  localparam logic [1:0] OUT_NONE   = 2'b00;
  localparam logic [1:0] OUT_RDADDR = 2'b01;
  localparam logic [1:0] OUT_WIMM   = 2'b10;
  localparam logic [1:0] OUT_WREG   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  function automatic int ent_width(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

  function automatic int ent_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int ent_mode_lsb(input int aw, input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/salidas_fifo.sv
// salidas_fifo: synchronous first-word-fall-through command FIFO.
// Ports:
//   Clk, Rst     clock (rising edge), asynchronous active-high reset
//   push, wdata  write request/data; ignored while full
//   pop, rdata   read request; rdata always shows the oldest entry
//   full, empty  occupancy flags
//   count        current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module salidas_fifo
  import salidas_pkg::*;
#(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/salidas_bus_ctrl.sv
// salidas_bus_ctrl: buffered output-bus controller.
// Commands from the control unit are queued and replayed on the external bus
// as SETUP (1 clk) / STROBE (LE_CYCLES clks) / HOLD (1 clk), so the core can
// issue output instructions back to back.
// Ports:
//   Clk, Rst          clock (rising edge), asynchronous active-high reset
//   Rx, Ry, num       operand sources; outbus selects the command mode
//   cmd_valid         command present; cmd_ready = FIFO not full
//   DataOut_Bus       registered data bus
//   Addres_Data_Bus   registered address bus
//   LE                latch enable, write modes only
//   RdAddr_Valid      read-address strobe, mode 01 only
//   busy              queue non-empty or a command in flight
//   overflow          sticky: a command arrived while the queue was full
//   fifo_count        queue occupancy
module salidas_bus_ctrl
  import salidas_pkg::*;
#(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int DEPTH     = 4,
  parameter int LE_CYCLES = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [AW-1:0]              Rx,
  input  logic [DW-1:0]              Ry,
  input  logic [DW-1:0]              num,
  input  logic [1:0]                 outbus,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic [DW-1:0]              DataOut_Bus,
  output logic [AW-1:0]              Addres_Data_Bus,
  output logic                       LE,
  output logic                       RdAddr_Valid,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int EW    = ent_width(AW, DW);
  localparam int A_LSB = ent_addr_lsb(DW);
  localparam int M_LSB = ent_mode_lsb(AW, DW);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int CNT_W = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LE_CYCLES - 1);

  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;
  logic             cmd_live;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       state;
  logic [1:0]       cur_mode;
  logic [CNT_W-1:0] strobe_cnt;

  assign cmd_live  = cmd_valid && (outbus != OUT_NONE);
  assign cmd_ready = (fifo_count != CW'(DEPTH));
  assign push      = cmd_live && cmd_ready;
  // A new command is taken only from IDLE or from HOLD, which chains
  // back-to-back commands without an idle cycle between them.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || (state == ST_HOLD));
  assign busy      = !fifo_empty || (state != ST_IDLE);

  always_comb begin
    wr_entry = '0;
    wr_entry[M_LSB +: 2] = outbus;
    case (outbus)
      OUT_RDADDR: wr_entry[A_LSB +: AW] = AW'(Ry);
      OUT_WIMM: begin
        wr_entry[A_LSB +: AW] = Rx;
        wr_entry[0 +: DW]     = num;
      end
      OUT_WREG: begin
        wr_entry[A_LSB +: AW] = Rx;
        wr_entry[0 +: DW]     = Ry;
      end
      default: wr_entry = '0;
    endcase
  end

  salidas_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= ST_IDLE;
      cur_mode        <= OUT_NONE;
      strobe_cnt      <= '0;
      DataOut_Bus     <= '0;
      Addres_Data_Bus <= '0;
      LE              <= 1'b0;
      RdAddr_Valid    <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (cmd_live && !cmd_ready) overflow <= 1'b1;

      case (state)
        ST_IDLE, ST_HOLD: begin
          LE           <= 1'b0;
          RdAddr_Valid <= 1'b0;
          if (pop) begin
            state           <= ST_SETUP;
            cur_mode        <= rd_entry[M_LSB +: 2];
            Addres_Data_Bus <= rd_entry[A_LSB +: AW];
            DataOut_Bus     <= rd_entry[0 +: DW];
          end else begin
            state           <= ST_IDLE;
            Addres_Data_Bus <= '0;
            DataOut_Bus     <= '0;
          end
        end
        ST_SETUP: begin
          state        <= ST_STROBE;
          strobe_cnt   <= CNT_LOAD;
          LE           <= (cur_mode == OUT_WIMM) || (cur_mode == OUT_WREG);
          RdAddr_Valid <= (cur_mode == OUT_RDADDR);
        end
        ST_STROBE: begin
          if (strobe_cnt == '0) begin
            state        <= ST_HOLD;
            LE           <= 1'b0;
            RdAddr_Valid <= 1'b0;
          end else begin
            strobe_cnt <= strobe_cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_salidas_bus_ctrl.sv
// Bench for salidas_bus_ctrl: two instances (DEPTH=4/LE_CYCLES=2 and
// DEPTH=2/LE_CYCLES=1) share one stimulus stream and are compared every cycle
// with a command-timeline model, plus directed constant checks.
module tb_salidas_bus_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [AW-1:0] Rx;
  logic [DW-1:0] Ry;
  logic [DW-1:0] num;
  logic [1:0]    outbus;
  logic          cmd_valid;

  logic          rdy0, le0, rd0, busy0, ovf0;
  logic [DW-1:0] d0;
  logic [AW-1:0] a0;
  logic [2:0]    cnt0;
  logic          rdy1, le1, rd1, busy1, ovf1;
  logic [DW-1:0] d1;
  logic [AW-1:0] a1;
  logic [1:0]    cnt1;

  salidas_bus_ctrl #(.DW(DW), .AW(AW), .DEPTH(4), .LE_CYCLES(2)) dut0 (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Ry(Ry), .num(num), .outbus(outbus),
    .cmd_valid(cmd_valid), .cmd_ready(rdy0), .DataOut_Bus(d0),
    .Addres_Data_Bus(a0), .LE(le0), .RdAddr_Valid(rd0), .busy(busy0),
    .overflow(ovf0), .fifo_count(cnt0)
  );

  salidas_bus_ctrl #(.DW(DW), .AW(AW), .DEPTH(2), .LE_CYCLES(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Ry(Ry), .num(num), .outbus(outbus),
    .cmd_valid(cmd_valid), .cmd_ready(rdy1), .DataOut_Bus(d1),
    .Addres_Data_Bus(a1), .LE(le1), .RdAddr_Valid(rd1), .busy(busy1),
    .overflow(ovf1), .fifo_count(cnt1)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0]    mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Model: a queue of accepted commands per instance, and the command on the
  // bus with its age in clocks since its SETUP cycle (0 = SETUP,
  // 1..LE = strobe, LE+1 = HOLD).
  ent_t mbuf [2][8];
  int   mhead [2];
  int   mn    [2];
  int   moff  [2];
  bit   mact  [2];
  bit   movf  [2];
  ent_t mcur  [2];

  int npass  = 0;
  int ntotal = 0;
  int le_hi [2];
  int rd_hi [2];

  function automatic int mdepth(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic int mle(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mn[k] = 0; moff[k] = 0; mact[k] = 0; movf[k] = 0;
      mcur[k]  = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit   cmd, pop_ok, push_ok;
      ent_t e;
      cmd     = cmd_valid && (outbus != 2'b00);
      pop_ok  = (!mact[k] || moff[k] == mle(k) + 1) && (mn[k] > 0);
      push_ok = cmd && (mn[k] < mdepth(k));
      if (cmd && mn[k] == mdepth(k)) movf[k] = 1;
      if (mact[k]) begin
        if (moff[k] == mle(k) + 1) mact[k] = 0;
        else moff[k]++;
      end
      if (pop_ok) begin
        mcur[k]  = mbuf[k][mhead[k]];
        mhead[k] = (mhead[k] + 1) % 8;
        mn[k]--;
        mact[k]  = 1;
        moff[k]  = 0;
      end
      if (push_ok) begin
        e.mode = outbus;
        case (outbus)
          2'b01:   begin e.addr = Ry; e.data = '0;  end
          2'b10:   begin e.addr = Rx; e.data = num; end
          default: begin e.addr = Rx; e.data = Ry;  end
        endcase
        mbuf[k][(mhead[k] + mn[k]) % 8] = e;
        mn[k]++;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      logic [AW-1:0] ea, oa;
      logic [DW-1:0] ed, od;
      logic          ele, erd, ole, ord, obusy, oovf, ordy;
      logic [31:0]   ocnt;
      bit            strobing;
      strobing = mact[k] && (moff[k] >= 1) && (moff[k] <= mle(k));
      ea  = mact[k] ? mcur[k].addr : '0;
      ed  = mact[k] ? mcur[k].data : '0;
      ele = strobing && (mcur[k].mode != 2'b01);
      erd = strobing && (mcur[k].mode == 2'b01);
      if (k == 0) begin
        oa = a0; od = d0; ole = le0; ord = rd0; obusy = busy0; oovf = ovf0;
        ordy = rdy0; ocnt = 32'(cnt0);
      end else begin
        oa = a1; od = d1; ole = le1; ord = rd1; obusy = busy1; oovf = ovf1;
        ordy = rdy1; ocnt = 32'(cnt1);
      end
      if (ole === 1'b1) le_hi[k]++;
      if (ord === 1'b1) rd_hi[k]++;
      chk($sformatf("%s u%0d addr", ph, k), 32'(oa), 32'(ea));
      chk($sformatf("%s u%0d data", ph, k), 32'(od), 32'(ed));
      chk($sformatf("%s u%0d LE", ph, k), 32'(ole), 32'(ele));
      chk($sformatf("%s u%0d RdAddr_Valid", ph, k), 32'(ord), 32'(erd));
      chk($sformatf("%s u%0d busy", ph, k), 32'(obusy), 32'(mact[k] || mn[k] > 0));
      chk($sformatf("%s u%0d overflow", ph, k), 32'(oovf), 32'(movf[k]));
      chk($sformatf("%s u%0d fifo_count", ph, k), ocnt, 32'(mn[k]));
      chk($sformatf("%s u%0d cmd_ready", ph, k), 32'(ordy), 32'(mn[k] != mdepth(k)));
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] m, input logic [7:0] rx,
                       input logic [7:0] ry, input logic [7:0] nm, input string ph);
    cmd_valid = v; outbus = m; Rx = rx; Ry = ry; num = nm;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_all(ph);
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, ph);
  endtask

  task automatic clr_counts();
    le_hi[0] = 0; le_hi[1] = 0; rd_hi[0] = 0; rd_hi[1] = 0;
  endtask

  initial begin
    Rst = 1'b1; cmd_valid = 1'b0; outbus = 2'b00; Rx = '0; Ry = '0; num = '0;
    model_reset();
    clr_counts();
    repeat (2) @(negedge Clk);
    check_all("reset");
    Rst = 1'b0;

    // Single write-immediate.
    clr_counts();
    cycle(1'b1, 2'b10, 8'h3C, 8'h00, 8'hA5, "wimm");
    idle(1, "wimm");
    chk("wimm addr N+1", 32'(a0), 32'h3C);
    chk("wimm data N+1", 32'(d0), 32'hA5);
    idle(1, "wimm");
    chk("wimm LE N+2", 32'(le0), 32'd1);
    idle(2, "wimm");
    chk("wimm LE N+4", 32'(le0), 32'd0);
    idle(1, "wimm");
    chk("wimm addr N+5", 32'(a0), 32'h00);
    idle(1, "wimm");
    chk("wimm LE length u0", 32'(le_hi[0]), 32'd2);
    chk("wimm LE length u1", 32'(le_hi[1]), 32'd1);
    chk("wimm no RdAddr u0", 32'(rd_hi[0]), 32'd0);

    // Single read-address.
    clr_counts();
    cycle(1'b1, 2'b01, 8'h55, 8'h7E, 8'hFF, "rdaddr");
    idle(1, "rdaddr");
    chk("rdaddr addr N+1", 32'(a0), 32'h7E);
    chk("rdaddr data N+1", 32'(d0), 32'h00);
    idle(6, "rdaddr");
    chk("rdaddr strobe length u0", 32'(rd_hi[0]), 32'd2);
    chk("rdaddr strobe length u1", 32'(rd_hi[1]), 32'd1);
    chk("rdaddr LE never u0", 32'(le_hi[0]), 32'd0);
    chk("rdaddr LE never u1", 32'(le_hi[1]), 32'd0);

    // Five back-to-back register writes.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 2'b11, 8'(8'h10 + i), 8'(i + 1), 8'h00, "burst");
    chk("burst full count u0", 32'(cnt0), 32'd4);
    chk("burst ready low u0", 32'(rdy0), 32'd0);
    chk("burst no overflow u0", 32'(ovf0), 32'd0);
    chk("burst overflow u1", 32'(ovf1), 32'd1);
    idle(24, "burst_drain");

    // Mode 00 with valid is ignored.
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b00, 8'hAA, 8'hBB, 8'hCC, "none");
    chk("none busy u0", 32'(busy0), 32'd0);
    chk("none count u0", 32'(cnt0), 32'd0);

    // Asynchronous reset in the middle of a strobe.
    cycle(1'b1, 2'b11, 8'h9A, 8'h6B, 8'h00, "pre_rst");
    idle(2, "pre_rst");
    chk("pre_rst LE high u0", 32'(le0), 32'd1);
    Rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    check_all("rst_release");
    clr_counts();
    cycle(1'b1, 2'b10, 8'h21, 8'h00, 8'h43, "post_rst");
    idle(1, "post_rst");
    chk("post_rst addr", 32'(a0), 32'h21);
    idle(6, "post_rst");
    chk("post_rst LE length u0", 32'(le_hi[0]), 32'd2);
    chk("post_rst LE length u1", 32'(le_hi[1]), 32'd1);

    // Push coinciding with a pop in HOLD on the shallow instance.
    cycle(1'b1, 2'b11, 8'hA1, 8'h11, 8'h00, "holdpush");
    cycle(1'b1, 2'b10, 8'hB2, 8'h00, 8'h22, "holdpush");
    idle(2, "holdpush");
    chk("holdpush count before u1", 32'(cnt1), 32'd1);
    cycle(1'b1, 2'b11, 8'hC3, 8'h33, 8'h00, "holdpush");
    chk("holdpush count after u1", 32'(cnt1), 32'd1);
    chk("holdpush next addr u1", 32'(a1), 32'hB2);
    idle(16, "holdpush_drain");

    // Random traffic.
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom), 8'($urandom), "rand");
    idle(40, "rand_drain");
    chk("final idle u0", 32'(busy0), 32'd0);
    chk("final idle u1", 32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
